// File: rtl/taillight_cmd.sv
// Switch conditioner for the taillight controller: synchronises and debounces the
// hazard/left/right switches and resolves them into one registered, one-hot command.
module taillight_cmd #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_haz,
    input  logic sw_left,
    input  logic sw_right,
    output logic haz,
    output logic left,
    output logic right,
    output logic mode_chg
);

    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LEFT  = 2'd1;
    localparam logic [1:0] S_RIGHT = 2'd2;
    localparam logic [1:0] S_HAZ   = 2'd3;

    // Channel order: [2] hazard, [1] left, [0] right
    logic [NCH-1:0] sw;
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] db;
    logic [CW-1:0]  cnt [NCH];

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [1:0] target;
    logic       chg_q;

    assign sw = {sw_haz, sw_left, sw_right};

    // Two-flop synchroniser per switch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Both turn switches together mean hazard
    always_comb begin
        target = S_IDLE;
        if (db[2] || (db[1] && db[0])) begin
            target = S_HAZ;
        end else if (db[1]) begin
            target = S_LEFT;
        end else if (db[0]) begin
            target = S_RIGHT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Active-to-active changes pass through IDLE so the light sequence restarts
    always_comb begin
        state_nxt = state;
        if (state == S_IDLE) begin
            state_nxt = target;
        end else if (target != state) begin
            state_nxt = S_IDLE;
        end
    end

    // Commands are registered alongside the state; mode_chg trails a state change by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            haz      <= 1'b0;
            left     <= 1'b0;
            right    <= 1'b0;
            chg_q    <= 1'b0;
            mode_chg <= 1'b0;
        end else begin
            haz      <= (state_nxt == S_HAZ);
            left     <= (state_nxt == S_LEFT);
            right    <= (state_nxt == S_RIGHT);
            chg_q    <= (state_nxt != state);
            mode_chg <= chg_q;
        end
    end

endmodule

// File: tb/tb_taillight_cmd.sv
// Randomised and directed bench for taillight_cmd: a window-based reference model feeds
// a scoreboard queue that a separate monitor drains every cycle.
module tb_taillight_cmd;

    localparam int unsigned DC = 4;

    localparam int M_IDLE  = 0;
    localparam int M_LEFT  = 1;
    localparam int M_RIGHT = 2;
    localparam int M_HAZ   = 3;

    logic clk = 1'b0;
    logic rst;
    logic sw_haz, sw_left, sw_right;
    logic haz, left, right, mode_chg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] sb_q [$];

    taillight_cmd #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_haz   (sw_haz),
        .sw_left  (sw_left),
        .sw_right (sw_right),
        .haz      (haz),
        .left     (left),
        .right    (right),
        .mode_chg (mode_chg)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last DC synced samples all disagree with it
    logic [2:0]    m_p1, m_p2, m_db;
    logic [DC-1:0] m_win [3];
    int            m_mode;
    logic          m_chg_prev;

    always @(posedge clk) begin
        logic [2:0] smp;
        logic [3:0] e;
        int         tgt;
        int         nxt;
        if (rst) begin
            m_p1 = '0;
            m_p2 = '0;
            m_db = '0;
            for (int c = 0; c < 3; c++) m_win[c] = '0;
            m_mode = M_IDLE;
            m_chg_prev = 1'b0;
            sb_q.push_back(4'b0000);
        end else begin
            smp  = m_p2;
            m_p2 = m_p1;
            m_p1 = {sw_haz, sw_left, sw_right};
            if (m_db[2] || (m_db[1] && m_db[0])) tgt = M_HAZ;
            else if (m_db[1])                    tgt = M_LEFT;
            else if (m_db[0])                    tgt = M_RIGHT;
            else                                 tgt = M_IDLE;
            for (int c = 0; c < 3; c++) begin
                m_win[c] = {m_win[c][DC-2:0], smp[c]};
                if (m_db[c] ? (m_win[c] == '0) : (&m_win[c])) m_db[c] = ~m_db[c];
            end
            if (m_mode == M_IDLE)   nxt = tgt;
            else if (tgt == m_mode) nxt = m_mode;
            else                    nxt = M_IDLE;
            e = {nxt == M_HAZ, nxt == M_LEFT, nxt == M_RIGHT, m_chg_prev};
            m_chg_prev = (nxt != m_mode);
            m_mode = nxt;
            sb_q.push_back(e);
        end
    end

    // Monitor: compare every presented cycle, plus one-hot and IDLE-gap properties
    logic [2:0] prev_cmd = 3'b000;
    always @(negedge clk) begin
        logic [3:0] exp_v;
        logic [3:0] act_v;
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            if (rst) exp_v = 4'b0000;
            act_v = {haz, left, right, mode_chg};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t actual haz,left,right,chg=%b required=%b",
                         $time, act_v, exp_v);
            end
            n_checks++;
            if ($countones({haz, left, right}) > 1) begin
                n_fail++;
                $display("FAIL onehot t=%0t actual=%b required=at most one high",
                         $time, {haz, left, right});
            end
            if (prev_cmd != 3'b000 && {haz, left, right} != 3'b000) begin
                n_checks++;
                if (prev_cmd != {haz, left, right}) begin
                    n_fail++;
                    $display("FAIL idle_gap t=%0t actual=%b after %b required=all-zero cycle between",
                             $time, {haz, left, right}, prev_cmd);
                end
            end
            prev_cmd = rst ? 3'b000 : {haz, left, right};
        end
    end

    function automatic logic pick(input int which);
        case (which)
            0:       return haz;
            1:       return left;
            default: return right;
        endcase
    endfunction

    // Edge 0 is the first posedge after the call; checks the edge at which the command rises
    task automatic check_rise(input int which, input int exp_edges, input string name);
        int n;
        n = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (pick(which)) begin
                n = k;
                break;
            end
        end
        n_checks++;
        if (n != exp_edges) begin
            n_fail++;
            $display("FAIL %s actual edges=%0d required=%0d", name, n, exp_edges);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        sw_haz = 1'b0;
        sw_left = 1'b1;
        sw_right = 1'b0;

        // Reset held with left switch on; re-debounce after release
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        check_rise(1, DC + 2, "reset_left_latency");
        settle(10);

        // Left to right in one cycle: IDLE gap then right
        @(negedge clk);
        sw_left = 1'b0;
        sw_right = 1'b1;
        check_rise(2, DC + 3, "left_to_right");
        settle(10);

        // Both turns give hazard, dropping right gives left
        @(negedge clk);
        sw_left = 1'b1;
        check_rise(0, DC + 3, "both_turns_haz");
        settle(10);
        @(negedge clk);
        sw_right = 1'b0;
        check_rise(1, DC + 3, "haz_to_left");
        settle(10);

        // Clear, then bounce the right switch
        @(negedge clk);
        sw_left = 1'b0;
        settle(12);
        @(negedge clk) sw_right = 1'b1;
        @(negedge clk) sw_right = 1'b0;
        @(negedge clk) sw_right = 1'b1;
        @(negedge clk) sw_right = 1'b0;
        @(negedge clk) sw_right = 1'b1;
        check_rise(2, DC + 2, "bounce_right");
        settle(10);

        // Hazard, then an unaligned reset mid-operation
        @(negedge clk);
        sw_right = 1'b0;
        sw_haz = 1'b1;
        check_rise(0, DC + 3, "right_to_haz");
        settle(5);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({haz, left, right, mode_chg} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset actual=%b required=0000", {haz, left, right, mode_chg});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        check_rise(0, DC + 2, "haz_after_reset");
        settle(10);

        // Random switches with occasional unaligned resets
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) sw_haz   = ~sw_haz;
            if ($urandom_range(0, 7) == 0)  sw_left  = ~sw_left;
            if ($urandom_range(0, 7) == 0)  sw_right = ~sw_right;
            if ($urandom_range(0, 499) == 0) begin
                #3 rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end

        @(negedge clk);
        sw_haz = 1'b0;
        sw_left = 1'b0;
        sw_right = 1'b0;
        settle(20);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
